sclk_serializer: RTL and testbench

- Downstream consumer of the integer clock divider's stretched output clock.
- Detects edges of the divided clock in the i_clk domain and shifts a parallel word out MSB-first. Each frame is framed by an active-low chip-select (SPI mode 0 style).
- Feeds serial DAC/codec interfaces in the DSP building-block chain.
- Everything runs on i_clk; the divided clock is used only as data, never as a clock.

---
 rtl/sclk_ser_pkg.sv | 26 ++
 rtl/sclk_serializer_if.sv | 33 +++
 rtl/clk_edge_det.sv | 23 ++
 rtl/sclk_serializer.sv | 143 ++++++++++++++
 tb/tb_sclk_serializer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sclk_ser_pkg.sv
// Shared state encoding, parameter limits and counter-width helper for the
// divided-clock serializer.
package sclk_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2
    } ser_state_t;

    localparam int unsigned DATA_WID_MIN = 32'd2;
    localparam int unsigned DATA_WID_MAX = 32'd32;

    // Smallest bit-counter width able to index data_wid bits (data_wid <= 32).
    function automatic int unsigned f_min_cnt_wid(input int unsigned data_wid);
        int unsigned f;
        f = 32'd1;
        for (int unsigned w = 32'd1; w <= 32'd5; w++) begin
            if ((32'd1 << w) < data_wid) begin
                f = w + 32'd1;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/sclk_serializer_if.sv
// Word handshake plus framed serial outputs of the serializer; the source
// drives through master, the serializer sits on slave.
interface sclk_serializer_if #(
    parameter int unsigned DATA_WID = 16
);
    logic [DATA_WID-1:0] i_data;
    logic                i_valid;
    logic                o_ready;
    logic                o_sdata;
    logic                o_sclk;
    logic                o_cs_n;
    logic                o_done;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_sdata,
        input  o_sclk,
        input  o_cs_n,
        input  o_done
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_sdata,
        output o_sclk,
        output o_cs_n,
        output o_done
    );
endinterface

// File: rtl/clk_edge_det.sv
// One-bit edge detector for a slow signal already synchronous to i_clk;
// reusable by any consumer of a divided clock.
module clk_edge_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);
    logic r_sig_d;

    // Previous-cycle copy of the monitored signal.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;
    assign o_fall = ~i_sig & r_sig_d;
endmodule

// File: rtl/sclk_serializer.sv
// MSB-first word serializer paced by a divided clock treated as data in the
// i_clk domain; each word is framed by an active-low chip select.
module sclk_serializer
    import sclk_ser_pkg::*;
#(
    parameter int unsigned DATA_WID = 16,
    parameter int unsigned CNT_WID  = 5
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_ce,
    input  logic                i_sclk,
    sclk_serializer_if.slave    bus
);
    localparam logic [CNT_WID-1:0] BITCNT_LOAD = CNT_WID'(DATA_WID - 32'd1);
    localparam logic [CNT_WID-1:0] BITCNT_ONE  = CNT_WID'(32'd1);
    localparam logic [CNT_WID-1:0] BITCNT_ZERO = {CNT_WID{1'b0}};

    if ((DATA_WID < DATA_WID_MIN) || (DATA_WID > DATA_WID_MAX) ||
        (CNT_WID < f_min_cnt_wid(DATA_WID))) begin : g_bad_param
        $error("sclk_serializer: illegal DATA_WID/CNT_WID combination");
    end

    ser_state_t          r_state, w_state_nxt;
    logic [DATA_WID-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_WID-1:0]  r_bitcnt, w_bitcnt_nxt;
    logic                r_sdata, w_sdata_nxt;
    logic                r_sclk, w_sclk_nxt;
    logic                r_cs_n, w_cs_n_nxt;
    logic                r_done, w_done_nxt;
    logic                w_rise, w_fall, w_sclk_d, w_ready, w_accept;

    clk_edge_det u_edge_det (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_sig  (i_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // The detector's delayed copy differs from i_sclk exactly when an edge is flagged.
    assign w_sclk_d = i_sclk ^ (w_rise | w_fall);

    // Masking with r_done keeps an accept out of the end-of-frame cycle.
    assign w_ready  = (r_state == IDLE) & i_ce & ~r_done;
    assign w_accept = bus.i_valid & w_ready;

    // Next-state and datapath decode; everything holds while i_ce is low.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_sdata_nxt  = r_sdata;
        w_sclk_nxt   = r_sclk;
        w_cs_n_nxt   = r_cs_n;
        w_done_nxt   = 1'b0;
        if (i_ce) begin
            w_sclk_nxt = (r_state == SHIFT) ? w_sclk_d : 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_shreg_nxt  = bus.i_data;
                        w_bitcnt_nxt = BITCNT_LOAD;
                        w_state_nxt  = ALIGN;
                    end else begin
                        w_state_nxt  = IDLE;
                    end
                end
                ALIGN: begin
                    if (w_fall) begin
                        w_cs_n_nxt  = 1'b0;
                        w_sdata_nxt = r_shreg[DATA_WID-1];
                        w_shreg_nxt = {r_shreg[DATA_WID-2:0], 1'b0};
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = ALIGN;
                    end
                end
                SHIFT: begin
                    if (w_fall && (r_bitcnt == BITCNT_ZERO)) begin
                        w_cs_n_nxt  = 1'b1;
                        w_sdata_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_fall) begin
                        w_sdata_nxt  = r_shreg[DATA_WID-1];
                        w_shreg_nxt  = {r_shreg[DATA_WID-2:0], 1'b0};
                        w_bitcnt_nxt = r_bitcnt - BITCNT_ONE;
                    end else begin
                        w_state_nxt  = SHIFT;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cs_n_nxt  = 1'b1;
                    w_sdata_nxt = 1'b0;
                    w_sclk_nxt  = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, shift register, counter and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_shreg  <= {DATA_WID{1'b0}};
            r_bitcnt <= BITCNT_ZERO;
            r_sdata  <= 1'b0;
            r_sclk   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_sdata  <= w_sdata_nxt;
            r_sclk   <= w_sclk_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_sdata = r_sdata;
    assign bus.o_sclk  = r_sclk;
    assign bus.o_cs_n  = r_cs_n;
    assign bus.o_done  = r_done;

`ifdef FORMAL
    a_state_legal: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (2'(r_state) != 2'd3));
    a_cs_only_shift: assert property (@(posedge i_clk) disable iff (!i_rstn)
        (r_state != SHIFT) |-> r_cs_n);
    a_ce_hold: assert property (@(posedge i_clk) disable iff (!i_rstn)
        $past(!i_ce) |-> ($stable(r_sdata) && $stable(r_sclk) && $stable(r_cs_n) && !r_done));
    a_done_pulse: assert property (@(posedge i_clk) disable iff (!i_rstn)
        r_done |=> !r_done);
`endif

endmodule

// File: tb/tb_sclk_serializer.sv
// Directed bench: an 8-bit and a 2-bit serializer share one divided clock
// (period 8 i_clk cycles); bits are captured on o_sclk rises.
module tb_sclk_serializer;
    logic clk     = 1'b0;
    logic rstn    = 1'b1;
    logic ce      = 1'b1;
    logic sclk_in = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;

    sclk_serializer_if #(.DATA_WID(8)) bus8 ();
    sclk_serializer_if #(.DATA_WID(2)) bus2 ();

    sclk_serializer #(.DATA_WID(8), .CNT_WID(5)) dut8 (
        .i_clk(clk), .i_rstn(rstn), .i_ce(ce), .i_sclk(sclk_in), .bus(bus8)
    );
    sclk_serializer #(.DATA_WID(2), .CNT_WID(5)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_ce(ce), .i_sclk(sclk_in), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Divided clock: toggles every 4 i_clk cycles, free running.
    initial begin : sclk_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 4) begin
                cnt = 0;
                sclk_in = ~sclk_in;
            end
        end
    end

    logic [1:0]  mon_sclk, mon_sdata, mon_done;
    logic [1:0]  sclk_q      = 2'b00;
    logic [31:0] bits [2]    = '{32'd0, 32'd0};
    int          nbits [2]   = '{0, 0};
    int          ndone [2]   = '{0, 0};
    int          cs_low_cnt  = 0;
    int          cs_hi_run   = 0;
    int          cs_gap_last = 0;
    logic        cs_prev     = 1'b1;

    assign mon_sclk  = {bus2.o_sclk,  bus8.o_sclk};
    assign mon_sdata = {bus2.o_sdata, bus8.o_sdata};
    assign mon_done  = {bus2.o_done,  bus8.o_done};

    // Receiver model: capture on o_sclk rise, count done cycles and cs_n runs.
    always @(negedge clk) begin
        sclk_q <= mon_sclk;
        for (int k = 0; k < 2; k++) begin
            if (mon_sclk[k] && !sclk_q[k]) begin
                bits[k]  <= {bits[k][30:0], mon_sdata[k]};
                nbits[k] <= nbits[k] + 1;
            end
            if (mon_done[k]) begin
                ndone[k] <= ndone[k] + 1;
            end
        end
        if (bus8.o_cs_n) begin
            cs_hi_run <= cs_hi_run + 1;
        end else begin
            cs_low_cnt <= cs_low_cnt + 1;
            if (cs_prev) begin
                cs_gap_last <= cs_hi_run;
            end
            cs_hi_run <= 0;
        end
        cs_prev <= bus8.o_cs_n;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] d, input string tag);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        if (k == 0) begin
            bus8.i_data  = d;
            bus8.i_valid = 1'b1;
        end else begin
            bus2.i_data  = d[1:0];
            bus2.i_valid = 1'b1;
        end
        for (int i = 0; i < 400 && !acc; i++) begin
            step();
            if ((k == 0) ? bus8.o_ready : bus2.o_ready) acc = 1'b1;
        end
        @(posedge clk);
        #1;
        bus8.i_valid = 1'b0;
        bus2.i_valid = 1'b0;
        check_val({tag, "_accept_timeout"}, {31'd0, ~acc}, 32'd0);
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            step();
            if (ndone[k] >= target) hit = 1'b1;
        end
        check_val({tag, "_done_timeout"}, {31'd0, ~hit}, 32'd0);
    endtask

    task automatic wait_bits(input int k, input int target, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step();
            if (nbits[k] >= target) hit = 1'b1;
        end
        check_val({tag, "_bits_timeout"}, {31'd0, ~hit}, 32'd0);
    endtask

    initial begin : main
        int  nb, nd, cl;
        bit  low_seen;
        bus8.i_data = 8'h00; bus8.i_valid = 1'b0;
        bus2.i_data = 2'b00; bus2.i_valid = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cs_n",  {31'd0, bus8.o_cs_n},  32'd1);
        check_val("rst_sdata", {31'd0, bus8.o_sdata}, 32'd0);
        check_val("rst_sclk",  {31'd0, bus8.o_sclk},  32'd0);
        check_val("rst_done",  {31'd0, bus8.o_done},  32'd0);
        check_val("rst_cs_n2", {31'd0, bus2.o_cs_n},  32'd1);
        @(negedge clk);
        rstn = 1'b1;
        step();
        check_val("rst_ready", {31'd0, bus8.o_ready}, 32'd1);

        // Single word 0xA5
        nb = nbits[0]; nd = ndone[0]; cl = cs_low_cnt;
        send(0, 8'hA5, "t1");
        wait_done(0, nd + 1, "t1");
        step(); step();
        check_val("t1_nbits", nbits[0] - nb, 32'd8);
        check_val("t1_bits",  {24'd0, bits[0][7:0]}, 32'h0000_00A5);
        check_val("t1_ndone", ndone[0] - nd, 32'd1);
        check_val("t1_cs_low_cycles", cs_low_cnt - cl, 32'd64);
        check_val("t1_cs_n",  {31'd0, bus8.o_cs_n},  32'd1);
        check_val("t1_ready", {31'd0, bus8.o_ready}, 32'd1);

        // Back-to-back 0xFF then 0x00
        nb = nbits[0]; nd = ndone[0];
        send(0, 8'hFF, "t2a");
        send(0, 8'h00, "t2b");
        wait_done(0, nd + 2, "t2");
        step(); step();
        check_val("t2_nbits", nbits[0] - nb, 32'd16);
        check_val("t2_bits",  {16'd0, bits[0][15:0]}, 32'h0000_FF00);
        check_val("t2_ndone", ndone[0] - nd, 32'd2);
        check_val("t2_cs_gap", cs_gap_last, 32'd8);

        // Enable gap after the 3rd bit of 0x3C
        nb = nbits[0]; nd = ndone[0];
        send(0, 8'h3C, "t3");
        wait_bits(0, nb + 3, "t3");
        low_seen = 1'b0;
        for (int i = 0; i < 20 && !low_seen; i++) begin
            step();
            if (!bus8.o_sclk) low_seen = 1'b1;
        end
        check_val("t3_sclk_low_timeout", {31'd0, ~low_seen}, 32'd0);
        @(posedge clk);
        #1;
        ce = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("t3_gap_nbits", nbits[0] - nb, 32'd3);
        check_val("t3_gap_cs_n",  {31'd0, bus8.o_cs_n},  32'd0);
        check_val("t3_gap_sclk",  {31'd0, bus8.o_sclk},  32'd0);
        check_val("t3_gap_sdata", {31'd0, bus8.o_sdata}, 32'd1);
        check_val("t3_gap_ndone", ndone[0] - nd, 32'd0);
        ce = 1'b1;
        wait_done(0, nd + 1, "t3");
        step(); step();
        check_val("t3_nbits", nbits[0] - nb, 32'd8);
        check_val("t3_bits",  {24'd0, bits[0][7:0]}, 32'h0000_003C);
        check_val("t3_ndone", ndone[0] - nd, 32'd1);

        // Asynchronous reset after bit 4 of 0xC3
        nd = ndone[0]; nb = nbits[0];
        send(0, 8'hC3, "t4");
        wait_bits(0, nb + 4, "t4");
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_val("t4_cs_n",  {31'd0, bus8.o_cs_n},  32'd1);
        check_val("t4_sdata", {31'd0, bus8.o_sdata}, 32'd0);
        check_val("t4_sclk",  {31'd0, bus8.o_sclk},  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step();
        check_val("t4_ready", {31'd0, bus8.o_ready}, 32'd1);
        repeat (30) step();
        check_val("t4_ndone", ndone[0] - nd, 32'd0);
        check_val("t4_cs_n_after", {31'd0, bus8.o_cs_n}, 32'd1);

        // Valid pulse with 0x81 while 0x66 is shifting
        nb = nbits[0]; nd = ndone[0];
        send(0, 8'h66, "t5");
        wait_bits(0, nb + 2, "t5");
        @(posedge clk);
        #1;
        bus8.i_data  = 8'h81;
        bus8.i_valid = 1'b1;
        step();
        check_val("t5_busy_ready", {31'd0, bus8.o_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus8.i_valid = 1'b0;
        wait_done(0, nd + 1, "t5");
        step(); step();
        check_val("t5_nbits", nbits[0] - nb, 32'd8);
        check_val("t5_bits",  {24'd0, bits[0][7:0]}, 32'h0000_0066);
        check_val("t5_ndone", ndone[0] - nd, 32'd1);
        repeat (32) step();
        check_val("t5_no_extra_bits", nbits[0] - nb, 32'd8);
        check_val("t5_cs_n_idle", {31'd0, bus8.o_cs_n}, 32'd1);
        check_val("t5_ready",     {31'd0, bus8.o_ready}, 32'd1);

        // Two-bit serializer, word 2'b10
        nb = nbits[1]; nd = ndone[1];
        send(1, 8'h02, "t6");
        wait_done(1, nd + 1, "t6");
        step(); step();
        check_val("t6_nbits", nbits[1] - nb, 32'd2);
        check_val("t6_bits",  {30'd0, bits[1][1:0]}, 32'd2);
        check_val("t6_ndone", ndone[1] - nd, 32'd1);
        check_val("t6_cs_n",  {31'd0, bus2.o_cs_n}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
